// File: rtl/led_fx_pkg.sv
// rtl/led_fx_pkg.sv - shared LED effect constants and helpers
// gamma_sq switches to square-law correction when LED_TRAIL_GAMMA_EN is defined.
package led_fx_pkg;

   localparam int LED_COUNT = 8;

   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

   // Maps a target brightness to the value compared against the PWM counter.
   function automatic int unsigned gamma_sq(input int unsigned b, input int unsigned bits);
`ifdef LED_TRAIL_GAMMA_EN
      return (b * b) >> bits;
`else
      return b & ((32'd1 << bits) - 32'd1);
`endif
   endfunction

endpackage

// File: rtl/led_trail_fader_if.sv
// rtl/led_trail_fader_if.sv - pattern/step link from the LED sequencer
interface led_trail_fader_if;

   logic [7:0] i_led;
   logic       i_step;

   modport master (output i_led, output i_step);
   modport slave  (input  i_led, input  i_step);

endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED: decaying brightness, frame latch and PWM compare
module led_pwm_channel
   import led_fx_pkg::*;
#(
   parameter int PWM_BITS   = 4,
   parameter int DECAY_STEP = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic                step_i,
   input  logic                led_i,
   input  logic                latch_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                pwm_o
);

   localparam int unsigned MAX = (1 << PWM_BITS) - 1;

   logic [PWM_BITS-1:0] bright_q, bright_d;
   logic [PWM_BITS-1:0] active_q, active_d;
   logic                pwm_q, pwm_d;

   always_comb begin
      bright_d = bright_q;
      active_d = active_q;
      pwm_d    = 1'b0;
      if (enable_i) begin
         if (step_i) begin
            bright_d = led_i ? PWM_BITS'(MAX)
                             : PWM_BITS'(sat_sub(32'(bright_q), DECAY_STEP));
         end
         // Latch samples the pre-step brightness so a frame never changes mid-way.
         if (latch_i) begin
            active_d = PWM_BITS'(gamma_sq(32'(bright_q), PWM_BITS));
         end
         pwm_d = (active_q > pwm_cnt_i);
      end else begin
         bright_d = '0;
         active_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bright_q <= '0;
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         bright_q <= bright_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/led_trail_fader.sv
// rtl/led_trail_fader.sv - comet-tail LED fader: shared PWM counter plus per-LED channels
// Build option LED_TRAIL_GAMMA_EN selects square-law brightness correction.
module led_trail_fader
   import led_fx_pkg::*;
#(
   parameter int PWM_BITS   = 4,
   parameter int DECAY_STEP = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   led_trail_fader_if.slave     seq,
   input  logic                 i_enable,
   output logic [LED_COUNT-1:0] o_pwm,
   output logic                 o_frame
);

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                frame_q, frame_d;
   logic                latch;

   always_comb begin
      pwm_cnt_d = '0;
      frame_d   = 1'b0;
      if (i_enable) begin
         pwm_cnt_d = pwm_cnt_q + 1'b1;
         frame_d   = (pwm_cnt_q == '0);
      end
   end

   assign latch = (pwm_cnt_q == CNT_MAX);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pwm_cnt_q <= '0;
         frame_q   <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         frame_q   <= frame_d;
      end
   end

   assign o_frame = frame_q;

   for (genvar g = 0; g < LED_COUNT; g++) begin : g_chan
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_chan (
         .clk_i     (i_clk),
         .rst_ni    (i_reset_n),
         .enable_i  (i_enable),
         .step_i    (seq.i_step),
         .led_i     (seq.i_led[g]),
         .latch_i   (latch),
         .pwm_cnt_i (pwm_cnt_q),
         .pwm_o     (o_pwm[g])
      );
   end

endmodule

// File: tb/tb_led_trail_fader.sv
// tb/tb_led_trail_fader.sv - randomized and directed bench for led_trail_fader
module tb_led_trail_fader;

   localparam int MAXV  = 15;
   localparam int DECAY = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] o_pwm;
   logic       o_frame;

   led_trail_fader_if seq_if ();

   led_trail_fader dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .seq       (seq_if.slave),
      .i_enable  (en),
      .o_pwm     (o_pwm),
      .o_frame   (o_frame)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference: frame phase, brightness and frame-stable duty per LED
   int         m_phase;
   int         m_bright[8];
   int         m_duty[8];
   logic [7:0] m_pwm;
   logic       m_frame;
   int         duty[8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int shown(input int b);
`ifdef LED_TRAIL_GAMMA_EN
      return (b * b) / 16;
`else
      return b;
`endif
   endfunction

   function automatic int decayed(input int k);
      return (MAXV - DECAY * k > 0) ? MAXV - DECAY * k : 0;
   endfunction

   task automatic model_clear();
      m_phase = 0;
      m_pwm   = 8'h00;
      m_frame = 1'b0;
      for (int i = 0; i < 8; i++) begin
         m_bright[i] = 0;
         m_duty[i]   = 0;
      end
   endtask

   task automatic model_advance();
      if (!en) begin
         model_clear();
      end else begin
         m_frame = (m_phase == 0);
         for (int i = 0; i < 8; i++) begin
            m_pwm[i] = (m_phase < m_duty[i]);
            if (m_phase == MAXV) m_duty[i] = shown(m_bright[i]);
            if (seq_if.i_step) begin
               if (seq_if.i_led[i]) m_bright[i] = MAXV;
               else m_bright[i] = (m_bright[i] > DECAY) ? m_bright[i] - DECAY : 0;
            end
         end
         m_phase = (m_phase + 1) % 16;
      end
   endtask

   task automatic cycle();
      model_advance();
      @(posedge clk);
      #1;
      check("pwm", o_pwm, m_pwm);
      check("frame", o_frame, m_frame);
   endtask

   task automatic run_frame();
      int guard = 0;
      for (int i = 0; i < 8; i++) duty[i] = 0;
      while (o_frame !== 1'b1 && guard < 40) begin
         cycle();
         guard++;
      end
      check("frame_wait", guard < 40, 1);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) cycle();
         for (int i = 0; i < 8; i++) duty[i] += o_pwm[i];
      end
   endtask

   task automatic step_cycle(input logic [7:0] led);
      seq_if.i_led  = led;
      seq_if.i_step = 1'b1;
      cycle();
      seq_if.i_step = 1'b0;
      seq_if.i_led  = 8'($urandom);
   endtask

   task automatic step_measure(input logic [7:0] led);
      step_cycle(led);
      run_frame();
      run_frame();
   endtask

   task automatic frame_period_check(input string tag);
      int first = -1;
      int second = -1;
      for (int c = 0; c < 40 && second < 0; c++) begin
         cycle();
         if (o_frame === 1'b1) begin
            if (first < 0) first = c;
            else second = c;
         end
      end
      check(tag, second - first, 16);
   endtask

   initial begin
      seq_if.i_led  = 8'h00;
      seq_if.i_step = 1'b0;
      model_clear();
      #3;
      check("reset_pwm", o_pwm, 8'h00);
      check("reset_frame", o_frame, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b1;
      frame_period_check("frame_period");

      // Single lit LED
      run_frame();
      step_measure(8'h01);
      check("single_led0", duty[0], shown(MAXV));
      check("single_others", duty[1] + duty[2] + duty[3] + duty[4] + duty[5] + duty[6] + duty[7], 0);

      // Decay behind a moving dot
      for (int k = 1; k <= 4; k++) begin
         step_measure(8'h02);
         check($sformatf("decay_led0_%0d", k), duty[0], shown(decayed(k)));
         check($sformatf("decay_led1_%0d", k), duty[1], shown(MAXV));
      end

      // Step landing on the latch cycle
      for (int c = 0; c < 15; c++) cycle();
      step_cycle(8'h80);
      run_frame();
      check("collide_old", duty[7], 0);
      run_frame();
      check("collide_new", duty[7], shown(MAXV));

      // Enable drop mid-frame
      for (int c = 0; c < 5; c++) cycle();
      en = 1'b0;
      cycle();
      check("drop_pwm", o_pwm, 8'h00);
      check("drop_frame", o_frame, 0);
      en = 1'b1;
      cycle();
      check("reenable_frame", o_frame, 1);
      for (int f = 0; f < 2; f++) begin
         run_frame();
         check("dark_after_enable", duty[0] + duty[1] + duty[2] + duty[3] + duty[4] + duty[5] + duty[6] + duty[7], 0);
      end

      // All LEDs lit, then saturating decay
      step_measure(8'hFF);
      for (int i = 0; i < 8; i++) check("multi_full", duty[i], shown(MAXV));
      for (int k = 1; k <= 8; k++) begin
         step_measure(8'h00);
         for (int i = 0; i < 8; i++) check($sformatf("sat_%0d_%0d", k, i), duty[i], shown(decayed(k)));
      end

      // Asynchronous reset mid-frame
      step_measure(8'h01);
      for (int c = 0; c < 3; c++) cycle();
      check("pre_reset_pwm", o_pwm, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_pwm", o_pwm, 8'h00);
      check("async_reset_frame", o_frame, 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      frame_period_check("frame_period_after_reset");

      // Random traffic against the reference
      for (int c = 0; c < 600; c++) begin
         en            = ($urandom_range(0, 24) != 0);
         seq_if.i_step = ($urandom_range(0, 3) == 0);
         seq_if.i_led  = ($urandom_range(0, 1) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         cycle();
      end
      seq_if.i_step = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 40; c++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0t exp=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
